// File: rtl/f1_light_seq_if.sv
// rtl/f1_light_seq_if.sv - start-light sequencer bundle: driver inputs and light/timing outputs
// Signals: trigger, react (driver side -> sequencer);
//          data_out, busy, rt, rt_valid, false_start (sequencer -> driver side).
// Modports: master = button/wrapper side, slave = sequencer.
interface f1_light_seq_if #(
    parameter int NLIGHTS = 8,
    parameter int RT_W    = 16
) ();
    logic               trigger;
    logic               react;
    logic [NLIGHTS-1:0] data_out;
    logic               busy;
    logic [RT_W-1:0]    rt;
    logic               rt_valid;
    logic               false_start;

    modport master (
        output trigger, react,
        input  data_out, busy, rt, rt_valid, false_start
    );

    modport slave (
        input  trigger, react,
        output data_out, busy, rt, rt_valid, false_start
    );
endinterface

// File: rtl/f1_light_seq.sv
// rtl/f1_light_seq.sv - start-light sequencer: light fill, random hold, false start, reaction timer
// Ports: clk (clock), rst (async active-low reset),
//        bus.slave: trigger/react in; data_out (light bar, bit 0 first), busy,
//        rt (last reaction time, held), rt_valid (1-cycle pulse), false_start (sticky) out.
module f1_light_seq #(
    parameter int                NLIGHTS   = 8,
    parameter int                TICK_DIV  = 54,
    parameter int                LFSR_W    = 7,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 7'h44,
    parameter int                MIN_DELAY = 2,
    parameter int                RT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    f1_light_seq_if.slave bus
);
    localparam int TCNT_W = $clog2(TICK_DIV);
    // Wide enough for the largest hold delay: (2^LFSR_W - 1) + MIN_DELAY.
    localparam int DLY_W  = $clog2((2 ** LFSR_W) + MIN_DELAY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEQ,
        S_HOLD,
        S_OUT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NLIGHTS-1:0]  data_out_q, data_out_d;
    logic [TCNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [DLY_W-1:0]    delay_q, delay_d;
    logic [RT_W-1:0]     rcnt_q, rcnt_d;
    logic [RT_W-1:0]     rt_q, rt_d;
    logic                rt_valid_q, rt_valid_d;
    logic                fs_q, fs_d;
    logic                busy_q, busy_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic                tick;
    logic [NLIGHTS-1:0]  shifted;

    assign tick    = ((state_q == S_SEQ) || (state_q == S_HOLD)) &&
                     (tick_cnt_q == TCNT_W'(TICK_DIV - 1));
    assign shifted = {data_out_q[NLIGHTS-2:0], 1'b1};

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        tick_cnt_d = tick_cnt_q;
        delay_d    = delay_q;
        rcnt_d     = rcnt_q;
        rt_d       = rt_q;
        rt_valid_d = 1'b0;
        fs_d       = fs_q;
        // Free-running; a non-zero seed never reaches the all-zero lock-up state.
        lfsr_d     = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

        if ((state_q == S_SEQ) || (state_q == S_HOLD)) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                data_out_d = '0;
                if (bus.trigger) begin
                    state_d    = S_SEQ;
                    tick_cnt_d = '0;
                end
            end
            S_SEQ: begin
                // A false start takes priority over any tick in the same cycle.
                if (bus.react) begin
                    state_d    = S_DONE;
                    fs_d       = 1'b1;
                    data_out_d = '0;
                end else if (tick) begin
                    data_out_d = shifted;
                    if (&shifted) begin
                        state_d    = S_HOLD;
                        tick_cnt_d = '0;
                        delay_d    = DLY_W'(lfsr_q) + DLY_W'(MIN_DELAY);
                    end
                end
            end
            S_HOLD: begin
                if (bus.react) begin
                    state_d    = S_DONE;
                    fs_d       = 1'b1;
                    data_out_d = '0;
                end else if (tick) begin
                    delay_d = delay_q - 1'b1;
                    // This tick brings the delay to zero: lights out, timer starts.
                    if (delay_q <= DLY_W'(1)) begin
                        state_d    = S_OUT;
                        data_out_d = '0;
                        rcnt_d     = '0;
                    end
                end
            end
            S_OUT: begin
                if (bus.react) begin
                    rt_d       = rcnt_q;
                    rt_valid_d = 1'b1;
                    state_d    = S_DONE;
                end else if (rcnt_q != {RT_W{1'b1}}) begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                data_out_d = '0;
                if (bus.trigger) begin
                    state_d    = S_SEQ;
                    tick_cnt_d = '0;
                    fs_d       = 1'b0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                data_out_d = '0;
            end
        endcase

        busy_d = (state_d == S_SEQ) || (state_d == S_HOLD) || (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            data_out_q <= '0;
            tick_cnt_q <= '0;
            delay_q    <= '0;
            rcnt_q     <= '0;
            rt_q       <= '0;
            rt_valid_q <= 1'b0;
            fs_q       <= 1'b0;
            busy_q     <= 1'b0;
            lfsr_q     <= LFSR_W'(1);
        end else begin
            state_q    <= state_d;
            data_out_q <= data_out_d;
            tick_cnt_q <= tick_cnt_d;
            delay_q    <= delay_d;
            rcnt_q     <= rcnt_d;
            rt_q       <= rt_d;
            rt_valid_q <= rt_valid_d;
            fs_q       <= fs_d;
            busy_q     <= busy_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.busy        = busy_q;
    assign bus.rt          = rt_q;
    assign bus.rt_valid    = rt_valid_q;
    assign bus.false_start = fs_q;
endmodule

// File: tb/tb_f1_light_seq.sv
// tb/tb_f1_light_seq.sv - scoreboard bench for f1_light_seq (16-bit and 4-bit reaction timers)
module tb_f1_light_seq;
    localparam int NL  = 4;
    localparam int TD  = 4;
    localparam int MD  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic trigger = 1'b0;
    logic react   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0]  m_lfsr;
    logic [3:0]  exp_do_q[$];
    logic [31:0] exp_rt_q[$];
    logic [31:0] exp_rt2_q[$];
    logic [31:0] last_rt  = 0;
    logic [31:0] last_rt2 = 0;

    f1_light_seq_if #(.NLIGHTS(NL), .RT_W(16)) bus  ();
    f1_light_seq_if #(.NLIGHTS(NL), .RT_W(4))  bus2 ();

    assign bus.trigger  = trigger;
    assign bus.react    = react;
    assign bus2.trigger = trigger;
    assign bus2.react   = react;

    f1_light_seq #(.NLIGHTS(NL), .TICK_DIV(TD), .LFSR_W(7), .LFSR_TAPS(7'h44),
                   .MIN_DELAY(MD), .RT_W(16))
        dut  (.clk(clk), .rst(rst), .bus(bus.slave));

    f1_light_seq #(.NLIGHTS(NL), .TICK_DIV(TD), .LFSR_W(7), .LFSR_TAPS(7'h44),
                   .MIN_DELAY(MD), .RT_W(4))
        dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    // Reference LFSR: x^7 tap set 7'h44, seeded to 1 by reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 7'd1;
        else      m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] fill(input int n);
        logic [4:0] v;
        v = (5'd1 << n) - 5'd1;
        return v[3:0];
    endfunction

    // Reaction-time scoreboard: every rt_valid pulse must match a pushed expectation.
    always @(negedge clk) begin
        if (bus.rt_valid) begin
            if (exp_rt_q.size() == 0) check("rt_valid_unexpected", 1, 0);
            else                      check("rt", 32'(bus.rt), exp_rt_q.pop_front());
        end
        if (bus2.rt_valid) begin
            if (exp_rt2_q.size() == 0) check("rt_valid_unexpected_w4", 1, 0);
            else                       check("rt_w4", 32'(bus2.rt), exp_rt2_q.pop_front());
        end
    end

    // mode 0: react in OUT after 'at' cycles; mode 1: react in HOLD cycle 'at'
    // (-1 = final HOLD tick); mode 2: reset asserted in HOLD cycle 'at'.
    task automatic do_run(input bit pulse_trig, input int mode, input int at);
        int k;
        int hold_len;
        int rj;
        @(negedge clk);
        trigger = 1'b1;
        for (int i = 0; i < TD * NL; i++) exp_do_q.push_back(fill(i / TD));
        for (int i = 0; i < TD * NL; i++) begin
            @(negedge clk);
            trigger = pulse_trig && (i == 5);
            check("fill_data_out", 32'(bus.data_out), 32'(exp_do_q.pop_front()));
            check("fill_busy", 32'(bus.busy), 1);
            if (i == 0) check("fs_cleared", 32'(bus.false_start), 0);
            if (i == TD * NL - 1) k = int'(m_lfsr) + MD;
        end
        hold_len = TD * k;
        rj = (at < 0) ? hold_len - 1 : at;
        for (int j = 0; j < hold_len; j++) begin
            @(negedge clk);
            trigger = pulse_trig && (j == 1);
            check("hold_data_out", 32'(bus.data_out), 32'hF);
            if (mode == 1 && j == rj) begin
                react = 1'b1;
                @(negedge clk);
                react = 1'b0;
                check("fs_data_out", 32'(bus.data_out), 0);
                check("fs_flag", 32'(bus.false_start), 1);
                check("fs_busy", 32'(bus.busy), 0);
                check("fs_rt_held", 32'(bus.rt), last_rt);
                check("fs_rt_held_w4", 32'(bus2.rt), last_rt2);
                check("fs_no_rt_valid", 32'(bus.rt_valid), 0);
                return;
            end
            if (mode == 2 && j == rj) begin
                rst = 1'b0;
                #1;
                check("rst_data_out", 32'(bus.data_out), 0);
                check("rst_busy", 32'(bus.busy), 0);
                check("rst_rt", 32'(bus.rt), 0);
                check("rst_rt_valid", 32'(bus.rt_valid), 0);
                check("rst_fs", 32'(bus.false_start), 0);
                check("rst_lfsr", 32'(dut.lfsr_q), 1);
                last_rt  = 0;
                last_rt2 = 0;
                @(negedge clk);
                rst = 1'b1;
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    check("post_rst_idle_busy", 32'(bus.busy), 0);
                    check("post_rst_idle_do", 32'(bus.data_out), 0);
                end
                return;
            end
        end
        @(negedge clk);
        check("out_data_out", 32'(bus.data_out), 0);
        check("out_busy", 32'(bus.busy), 1);
        for (int c = 1; c <= at; c++) begin
            @(negedge clk);
            trigger = pulse_trig && (c == 2);
        end
        trigger = 1'b0;
        react   = 1'b1;
        last_rt  = at;
        last_rt2 = (at > 15) ? 15 : at;
        exp_rt_q.push_back(last_rt);
        exp_rt2_q.push_back(last_rt2);
        @(negedge clk);
        react = 1'b0;
        check("done_rt_valid", 32'(bus.rt_valid), 1);
        check("done_busy", 32'(bus.busy), 0);
        check("done_data_out", 32'(bus.data_out), 0);
        @(negedge clk);
        check("rt_valid_one_cycle", 32'(bus.rt_valid), 0);
        check("rt_held", 32'(bus.rt), last_rt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(bus.data_out), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_rt", 32'(bus.rt), 0);
        check("reset_rt_valid", 32'(bus.rt_valid), 0);
        check("reset_fs", 32'(bus.false_start), 0);
        check("reset_lfsr", 32'(dut.lfsr_q), 1);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);

        do_run(1'b0, 0, 37);   // normal run, rt=37 (4-bit timer saturates to 15)
        do_run(1'b0, 1, 2);    // false start early in HOLD
        do_run(1'b0, 1, -1);   // false start on the final HOLD tick
        do_run(1'b0, 0, 0);    // react in the first OUT cycle
        do_run(1'b1, 0, 20);   // ignored trigger pulses; 4-bit timer saturates
        do_run(1'b0, 2, 3);    // reset mid-HOLD

        check("rt_queue_drained", exp_rt_q.size(), 0);
        check("rt_w4_queue_drained", exp_rt2_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/f1_light_seq.md
Name: f1_light_seq

Overview:
- Parametrised next-generation start-light sequencer: one self-contained block for the start-light control path (FSM, tick divider, random hold delay, LFSR).
- Adds a configurable light count and tick period, a false-start detector and a reaction-time measurement.
- Drives the light bar directly; a top-level wrapper connects the trigger and react buttons.

Parameters:
- NLIGHTS, 8, number of lights (>=2).
- TICK_DIV, 54, clk cycles per tick (>=2).
- LFSR_W, 7, LFSR width (>=3).
- LFSR_TAPS, 7'h44, Fibonacci tap mask; default gives x^7+x^3+1.
- MIN_DELAY, 2, ticks added to the LFSR value for the hold delay.
- RT_W, 16, reaction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- trigger  in  1  start request, level-sampled
- react  in  1  driver response, level-sampled
- data_out  out  NLIGHTS  light bar; bit 0 lights first
- busy  out  1  high in SEQ, HOLD, OUT
- rt  out  RT_W  last measured reaction time in cycles; held
- rt_valid  out  1  one-cycle pulse when rt updates
- false_start  out  1  sticky fault flag

Behaviour:
- Reset (rst=0, async): state=IDLE, data_out=0, rt=0, rt_valid=0, false_start=0, tick counter=0, delay counter=0, lfsr=1.
- LFSR
  - Free-runs every cycle, including IDLE.
  - Update: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - Never 0.
- Tick counter
  - Cleared to 0 on entry to SEQ and on entry to HOLD.
  - Increments each cycle in SEQ/HOLD; tick=1 when count==TICK_DIV-1, then wraps to 0.
- States
  - IDLE: data_out=0. trigger=1 -> SEQ.
  - SEQ
    - On each tick: data_out <= {data_out[NLIGHTS-2:0],1'b1}. The first light is on TICK_DIV cycles after entry.
    - On the tick that makes data_out all ones: -> HOLD; the delay counter loads K = lfsr + MIN_DELAY, using the lfsr value in that cycle.
  - HOLD
    - data_out stays all ones.
    - The delay counter decrements on each tick.
    - On the tick where it reaches 0: -> OUT, data_out <= 0, reaction counter <= 0.
  - OUT
    - Reaction counter increments each cycle and saturates at 2^RT_W-1.
    - react=1 -> rt <= counter value (0 if react is high in the first OUT cycle), rt_valid=1 for one cycle, -> DONE.
  - DONE: data_out=0. trigger=1 -> SEQ and clears false_start.
- False start
  - react=1 in SEQ or HOLD -> false_start <= 1, data_out <= 0, -> DONE. rt and rt_valid are unchanged.
  - If react coincides with the final HOLD tick, the false start wins.
- trigger in SEQ/HOLD/OUT: ignored; no restart.
- trigger and react both high in IDLE/DONE: trigger wins, -> SEQ. That react is not a false start because SEQ has not yet been entered.
- rst asserted mid-sequence: everything returns to reset values immediately; no rt_valid is produced.
- All outputs are registered.

Test Plan:
1. Reset values (NLIGHTS=4, TICK_DIV=4, MIN_DELAY=2): hold rst=0, then release -> data_out=0, busy=0, rt=0, false_start=0, lfsr=1.
2. Light fill (same params): pulse trigger in IDLE -> data_out goes 0001, 0011, 0111, 1111 on cycles 4, 8, 12, 16 after SEQ entry; busy=1 throughout.
3. Hold and release:
   - Force a known lfsr by counting cycles from reset, so K = lfsr + 2.
   - Expected: data_out=1111 held for K*4 cycles, then 0000.
   - react 37 cycles after lights out -> rt=37, rt_valid high for exactly 1 cycle, state DONE, busy=0.
4. False start: react=1 during HOLD -> data_out=0 the next cycle, false_start=1, rt unchanged, no rt_valid. A following trigger clears false_start and restarts SEQ.
5. Boundaries:
   - react on the exact final HOLD tick -> false_start=1.
   - react held high in the first OUT cycle -> rt=0.
   - With RT_W=4 and no react for 20 cycles -> counter saturates at 15; a later react gives rt=15.
6. Ignored trigger and mid-run reset:
   - trigger pulses in SEQ, HOLD and OUT -> no change to sequence timing.
   - Asserting rst mid-HOLD -> immediate return to reset values; after release the block stays in IDLE until trigger.
